spi_burst_slave: RTL and testbench
==================================

# spi_burst_slave

Parametrised SPI memory slave that succeeds the single-byte SPI memory slave. It supports configurable data width, address width and memory depth, and multi-word burst transfers with address auto-increment and wrap. It also flags frames with an out-of-range address or an early chip-select release. It sits behind the test-bench SPI master in the SPI_MEMORY environment and is clocked bit-per-cycle from the system clock.

## Interface
- DATA_W, 8: bits per memory word.
- ADDR_W, 5: address field width in the frame.
- DEPTH, 32: number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- LEN_W, 3: burst length field width; a burst moves LEN+1 words (1..2^LEN_W).
- clk  in  1  system clock; one serial bit per rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- cs  in  1  chip select, active-low.
- mosi  in  1  serial data in, LSB-first fields.
- miso  out  1  serial read data, LSB-first.
- ready  out  1  one-cycle pulse: read data about to start on miso.
- op_done  out  1  one-cycle pulse: frame completed normally.
- err  out  1  one-cycle pulse: frame aborted or address out of range.

## Operation
- Frame layout: cmd(1: 1=write, 0=read), ADDR, LEN, then payload.
  - Write payload: (LEN+1)·DATA_W bits on mosi.
  - Read payload: (LEN+1)·DATA_W bits on miso.
- All fields are LSB-first.
- State machine:
  - IDLE → DETECT when cs=0.
  - DETECT: sample cmd; → ADDR.
  - ADDR: ADDR_W samples; → LEN.
  - LEN: LEN_W samples. If address ≥ DEPTH → ERR. Otherwise write → WRITE, read → LOAD.
  - WRITE: shift DATA_W bits per word. The word commits to mem[addr] on the edge that samples its last bit. Then addr increments modulo DEPTH. After word LEN → DONE.
  - LOAD: ready=1 for one cycle; dout ← mem[addr]; → SEND.
  - SEND: drive one bit per cycle on miso. At each word boundary, fetch mem[addr+1 mod DEPTH] with no gap cycle. After the last bit → DONE.
  - DONE: op_done=1 for one cycle; → IDLE.
  - ERR: err=1 for one cycle; miso=0; → IDLE.
- cs=1 in any state other than IDLE/DONE/ERR → ERR next cycle.
  - Already-committed write words remain.
  - The partially shifted word is discarded.
- An out-of-range address performs no memory access; the payload is ignored.
- Memory initialises to all zeros at elaboration; rstn does not clear memory.

## Timing
- Reset values: miso=0, ready=0, op_done=0, err=0, state=IDLE, counters=0.
- rstn low mid-frame aborts immediately. No err pulse; no partial-word write.
- Write latency:
  - cs low at edge 0.
  - cmd sampled at edge 1.
  - Address at edges 2..1+ADDR_W.
  - LEN follows.
  - First data bit at edge 2+ADDR_W+LEN_W.
  - op_done is high in the cycle after the final word commit.
- Read: ready is high in the cycle after the last LEN bit. miso bit 0 of word 0 is valid the following cycle. Bits are contiguous for (LEN+1)·DATA_W cycles. op_done follows the last bit.
- miso returns to 0 in DONE, ERR and IDLE.
- Back-to-back frames: IDLE re-enters DETECT on the first cycle cs is low. The master holds cs high for at least one cycle between frames.
- Wrap-around: address DEPTH−1 increments to 0, never to DEPTH.

## Structure
- Package spi_mem_pkg holds:
  - state enum (IDLE, DETECT, ADDR, LEN, WRITE, LOAD, SEND, DONE, ERR);
  - CMD_WRITE=1 and CMD_READ=0 constants.
- Sub-module spi_mem_array(DATA_W, DEPTH): one synchronous write port and one combinational read port. The top holds the FSM, shift registers and counters.

## Test plan
- Single write then read, defaults: write 0xA5 to addr 3, LEN=0 → op_done once. Read addr 3 → ready, then miso 1,0,1,0,0,1,0,1, then op_done.
- Burst with wrap: write LEN=3 starting at addr 30 with data 0x11,0x22,0x33,0x44 → mem[30]=0x11, mem[31]=0x22, mem[0]=0x33, mem[1]=0x44. A burst read from 30 returns the same four words contiguously.
- Out-of-range: DEPTH=20; read addr 25 → err pulse after the LEN field, no ready, miso stays 0, memory unchanged.
- Early cs release: write LEN=1 at addr 5 with 0x0F, 0xF0; raise cs after 4 bits of word 1 → mem[5]=0x0F, mem[6] unchanged, err pulses once, op_done never asserts.
- Reset mid-read: assert rstn low during SEND → all outputs 0 asynchronously. The next frame after release works normally.
- Parameter sweep: DATA_W=16, ADDR_W=6, DEPTH=64, LEN_W=2; write 0xBEEF at addr 63 then read it back → exact match, latencies per the formulas above.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared definitions for the SPI burst memory slave.
// Contents:
//   state_t    - frame state machine encoding
//   CMD_WRITE  - command bit value for a write frame
//   CMD_READ   - command bit value for a read frame
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DETECT,
        S_ADDR,
        S_LEN,
        S_WRITE,
        S_LOAD,
        S_SEND,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/spi_mem_array.sv
// -----------------------------------------------------------------------------
// spi_mem_array
// Word memory behind the SPI slave: one synchronous write port and one
// combinational read port. Contents start at zero and are not affected by
// any reset.
// Ports:
//   clk      in   system clock
//   i_we     in   write enable, commits i_wdata to i_waddr on the rising edge
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module spi_mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Declaration initialiser gives the power-up zero contents.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spi_burst_slave.sv
// -----------------------------------------------------------------------------
// spi_burst_slave
// SPI memory slave with multi-word bursts. Frame: cmd (1 bit), address
// (ADDR_W bits), length (LEN_W bits, burst moves LEN+1 words), payload.
// All fields LSB-first, one bit per system clock while cs is low.
// Ports:
//   clk      in   system clock, one serial bit per rising edge
//   rstn     in   asynchronous active-low reset
//   cs       in   chip select, active-low
//   mosi     in   serial data in
//   miso     out  serial read data
//   ready    out  one-cycle pulse before read data starts on miso
//   op_done  out  one-cycle pulse when a frame completes normally
//   err      out  one-cycle pulse on abort or out-of-range address
// -----------------------------------------------------------------------------
module spi_burst_slave
    import spi_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int LEN_W  = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic ready,
    output logic op_done,
    output logic err
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAXF   = (DATA_W > ADDR_W) ? ((DATA_W > LEN_W) ? DATA_W : LEN_W)
                                              : ((ADDR_W > LEN_W) ? ADDR_W : LEN_W);
    localparam int CNT_W  = $clog2(MAXF + 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_word;
    logic [CNT_W-1:0]    r_bit;
    logic [DATA_W-2:0]   r_shift;
    logic [DATA_W-1:0]   r_dout;

    logic [ADDR_W:0]     w_addr_sh;
    logic [LEN_W:0]      w_len_sh;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_rd_data;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_addr_last;
    logic                w_len_last;
    logic                w_word_last;
    logic                w_burst_last;
    logic                w_oor;
    logic                w_abort;
    logic                w_we;

    // LSB-first fields: new bit enters at the top and moves down.
    assign w_addr_sh    = {mosi, r_addr};
    assign w_len_sh     = {mosi, r_len};
    assign w_wr_data    = {mosi, r_shift};

    assign w_addr_last  = (r_bit == CNT_W'(ADDR_W - 1));
    assign w_len_last   = (r_bit == CNT_W'(LEN_W - 1));
    assign w_word_last  = (r_bit == CNT_W'(DATA_W - 1));
    assign w_burst_last = w_word_last && (r_word == r_len);
    // Evaluated on the last LEN edge, when the address field is complete.
    assign w_oor        = ({1'b0, r_addr} >= DEPTH_V);
    assign w_addr_next  = ({1'b0, r_addr} == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
    assign w_abort      = cs && !(r_state inside {S_IDLE, S_DONE, S_ERR});
    // A partially shifted word never commits: cs high on the last-bit edge wins.
    assign w_we         = (r_state == S_WRITE) && !cs && w_word_last;
    // During SEND the port looks ahead so the next word loads with no gap.
    assign w_rd_addr    = (r_state == S_SEND) ? w_addr_next : r_addr;

    spi_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr[MEM_AW-1:0]),
        .i_wdata (w_wr_data),
        .i_raddr (w_rd_addr[MEM_AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        ready   = 1'b0;
        op_done = 1'b0;
        err     = 1'b0;
        miso    = 1'b0;
        case (r_state)
            S_IDLE:   if (!cs) w_next = S_DETECT;
            S_DETECT: w_next = S_ADDR;
            S_ADDR:   if (w_addr_last) w_next = S_LEN;
            S_LEN: begin
                if (w_len_last) begin
                    if (w_oor)                  w_next = S_ERR;
                    else if (r_cmd == CMD_WRITE) w_next = S_WRITE;
                    else                         w_next = S_LOAD;
                end
            end
            S_WRITE:  if (w_burst_last) w_next = S_DONE;
            S_LOAD: begin
                ready  = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                miso = r_dout[0];
                if (w_burst_last) w_next = S_DONE;
            end
            S_DONE: begin
                op_done = 1'b1;
                w_next  = S_IDLE;
            end
            S_ERR: begin
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_ERR;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_word  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_bit <= '0;
                S_DETECT: begin
                    r_cmd <= mosi;
                    r_bit <= '0;
                end
                S_ADDR: begin
                    r_addr <= w_addr_sh[ADDR_W:1];
                    r_bit  <= w_addr_last ? '0 : r_bit + CNT_W'(1);
                end
                S_LEN: begin
                    r_len  <= w_len_sh[LEN_W:1];
                    r_bit  <= w_len_last ? '0 : r_bit + CNT_W'(1);
                    r_word <= '0;
                end
                S_WRITE: begin
                    r_shift <= w_wr_data[DATA_W-1:1];
                    if (w_word_last) begin
                        r_bit  <= '0;
                        r_addr <= w_addr_next;
                        r_word <= r_word + LEN_W'(1);
                    end else begin
                        r_bit <= r_bit + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    r_dout <= w_rd_data;
                    r_bit  <= '0;
                end
                S_SEND: begin
                    if (w_word_last) begin
                        r_bit  <= '0;
                        r_addr <= w_addr_next;
                        r_word <= r_word + LEN_W'(1);
                        r_dout <= w_rd_data;
                    end else begin
                        r_bit  <= r_bit + CNT_W'(1);
                        r_dout <= r_dout >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_slave.sv
module tb_spi_burst_slave;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cs;
    logic       mosi;
    logic [1:0] sel;
    logic [2:0] cs_v;
    logic [2:0] miso_v;
    logic [2:0] ready_v;
    logic [2:0] done_v;
    logic [2:0] err_v;
    logic       miso;
    logic       ready;
    logic       op_done;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Only the selected instance sees chip select; the others stay idle.
    assign cs_v[0] = (sel == 2'd0) ? cs : 1'b1;
    assign cs_v[1] = (sel == 2'd1) ? cs : 1'b1;
    assign cs_v[2] = (sel == 2'd2) ? cs : 1'b1;
    assign miso    = miso_v[sel];
    assign ready   = ready_v[sel];
    assign op_done = done_v[sel];
    assign err     = err_v[sel];

    spi_burst_slave u_def (
        .clk(clk), .rstn(rstn), .cs(cs_v[0]), .mosi(mosi),
        .miso(miso_v[0]), .ready(ready_v[0]), .op_done(done_v[0]), .err(err_v[0])
    );

    spi_burst_slave #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .LEN_W(3)) u_d20 (
        .clk(clk), .rstn(rstn), .cs(cs_v[1]), .mosi(mosi),
        .miso(miso_v[1]), .ready(ready_v[1]), .op_done(done_v[1]), .err(err_v[1])
    );

    spi_burst_slave #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .LEN_W(2)) u_w16 (
        .clk(clk), .rstn(rstn), .cs(cs_v[2]), .mosi(mosi),
        .miso(miso_v[2]), .ready(ready_v[2]), .op_done(done_v[2]), .err(err_v[2])
    );

    function automatic int dw_of(input logic [1:0] s);
        return (s == 2'd2) ? 16 : 8;
    endfunction
    function automatic int aw_of(input logic [1:0] s);
        return (s == 2'd2) ? 6 : 5;
    endfunction
    function automatic int lw_of(input logic [1:0] s);
        return (s == 2'd2) ? 2 : 3;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drives cs low, cmd, address and length; returns at the falling edge
    // right after the edge that sampled the last LEN bit.
    task automatic hdr(input logic cmd, input int addr, input int len);
        int aw;
        int lw;
        aw = aw_of(sel);
        lw = lw_of(sel);
        @(negedge clk); cs = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = cmd;
        for (int i = 0; i < aw; i++) begin
            @(negedge clk); mosi = addr[i];
        end
        for (int i = 0; i < lw; i++) begin
            @(negedge clk); mosi = len[i];
        end
        @(negedge clk);
    endtask

    task automatic frame(input logic [1:0] s, input logic cmd, input int addr, input int len,
                         input logic [63:0] wd, input logic [63:0] ex, input logic eerr,
                         input string nm);
        int dw;
        logic [15:0] got;
        sel = s;
        dw  = dw_of(s);
        hdr(cmd, addr, len);
        if (eerr) begin
            chk1({nm, "_err"}, err, 1'b1);
            chk1({nm, "_noready"}, ready, 1'b0);
            chk1({nm, "_miso0"}, miso, 1'b0);
            cs = 1'b1;
            @(negedge clk);
            chk1({nm, "_errclr"}, err, 1'b0);
            chk1({nm, "_miso0b"}, miso, 1'b0);
            chk1({nm, "_nodone"}, op_done, 1'b0);
        end else if (cmd) begin
            chk1({nm, "_wr_quiet"}, ready | err | op_done, 1'b0);
            for (int w = 0; w <= len; w++) begin
                for (int b = 0; b < dw; b++) begin
                    if (!(w == 0 && b == 0)) begin
                        @(negedge clk);
                        chk1({nm, "_wr_quiet"}, ready | err | op_done, 1'b0);
                    end
                    mosi = wd[16*w + b];
                end
            end
            @(negedge clk);
            chk1({nm, "_wr_done"}, op_done, 1'b1);
            chk1({nm, "_wr_noerr"}, err, 1'b0);
            cs = 1'b1; mosi = 1'b0;
            @(negedge clk);
            chk1({nm, "_wr_doneclr"}, op_done, 1'b0);
        end else begin
            chk1({nm, "_ready"}, ready, 1'b1);
            chk1({nm, "_ready_miso0"}, miso, 1'b0);
            for (int w = 0; w <= len; w++) begin
                got = '0;
                for (int b = 0; b < dw; b++) begin
                    @(negedge clk);
                    got[b] = miso;
                    chk1({nm, "_rd_quiet"}, ready | err | op_done, 1'b0);
                end
                chkw($sformatf("%s_word%0d", nm, w), 32'(got), 32'(ex[16*w +: 16]));
            end
            @(negedge clk);
            chk1({nm, "_rd_done"}, op_done, 1'b1);
            chk1({nm, "_rd_done_miso0"}, miso, 1'b0);
            cs = 1'b1;
            @(negedge clk);
            chk1({nm, "_rd_doneclr"}, op_done, 1'b0);
        end
    endtask

    typedef struct {
        logic [1:0]  s;
        logic        cmd;
        int          addr;
        int          len;
        logic [63:0] wd;
        logic [63:0] ex;
        logic        eerr;
    } vec_t;

    vec_t       vt [16];
    logic [7:0] pat;

    initial begin
        // sel 0: defaults, sel 1: DEPTH=20, sel 2: 16-bit words, 6-bit addr, 2-bit len
        vt[0]  = '{2'd0, 1'b1, 3,  0, 64'h00A5, 64'h0, 1'b0};
        vt[1]  = '{2'd0, 1'b0, 3,  0, 64'h0, 64'h00A5, 1'b0};
        vt[2]  = '{2'd0, 1'b1, 30, 3, 64'h0044_0033_0022_0011, 64'h0, 1'b0};
        vt[3]  = '{2'd0, 1'b0, 30, 3, 64'h0, 64'h0044_0033_0022_0011, 1'b0};
        vt[4]  = '{2'd0, 1'b0, 0,  1, 64'h0, 64'h0044_0033, 1'b0};
        vt[5]  = '{2'd0, 1'b0, 31, 0, 64'h0, 64'h0022, 1'b0};
        vt[6]  = '{2'd1, 1'b1, 5,  0, 64'h005A, 64'h0, 1'b0};
        vt[7]  = '{2'd1, 1'b0, 25, 0, 64'h0, 64'h0, 1'b1};
        vt[8]  = '{2'd1, 1'b1, 20, 0, 64'h00FF, 64'h0, 1'b1};
        vt[9]  = '{2'd1, 1'b1, 19, 1, 64'h003C_00C3, 64'h0, 1'b0};
        vt[10] = '{2'd1, 1'b0, 19, 1, 64'h0, 64'h003C_00C3, 1'b0};
        vt[11] = '{2'd1, 1'b0, 5,  0, 64'h0, 64'h005A, 1'b0};
        vt[12] = '{2'd2, 1'b1, 63, 0, 64'hBEEF, 64'h0, 1'b0};
        vt[13] = '{2'd2, 1'b0, 63, 0, 64'h0, 64'hBEEF, 1'b0};
        vt[14] = '{2'd2, 1'b1, 63, 1, 64'h5678_1234, 64'h0, 1'b0};
        vt[15] = '{2'd2, 1'b0, 63, 1, 64'h0, 64'h5678_1234, 1'b0};

        sel  = 2'd0;
        cs   = 1'b1;
        mosi = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chkw("rst_miso",  32'(miso_v),  32'h0);
        chkw("rst_ready", 32'(ready_v), 32'h0);
        chkw("rst_done",  32'(done_v),  32'h0);
        chkw("rst_err",   32'(err_v),   32'h0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            frame(vt[i].s, vt[i].cmd, vt[i].addr, vt[i].len, vt[i].wd, vt[i].ex,
                  vt[i].eerr, $sformatf("v%0d", i));
        end

        // Early chip-select release during word 1 of a two-word write.
        frame(2'd0, 1'b1, 6, 0, 64'h0066, 64'h0, 1'b0, "pre6");
        sel = 2'd0;
        hdr(1'b1, 5, 1);
        pat = 8'h0F;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) @(negedge clk);
            mosi = pat[b];
        end
        pat = 8'hF0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            mosi = pat[b];
        end
        @(negedge clk);
        chk1("early_pre_err", err, 1'b0);
        cs = 1'b1;
        @(negedge clk);
        chk1("early_err", err, 1'b1);
        chk1("early_nodone", op_done, 1'b0);
        @(negedge clk);
        chk1("early_errclr", err, 1'b0);
        chk1("early_nodone2", op_done, 1'b0);
        frame(2'd0, 1'b0, 5, 1, 64'h0, 64'h0066_000F, 1'b0, "early_rb");

        // Asynchronous reset in the middle of a burst read.
        sel = 2'd0;
        hdr(1'b0, 30, 3);
        chk1("mrst_ready", ready, 1'b1);
        @(negedge clk);
        chk1("mrst_bit0", miso, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk1("mrst_miso", miso, 1'b0);
        chk1("mrst_ready0", ready, 1'b0);
        chk1("mrst_done0", op_done, 1'b0);
        chk1("mrst_err0", err, 1'b0);
        cs = 1'b1;
        @(negedge clk);
        chk1("mrst_noerr", err, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        frame(2'd0, 1'b0, 3, 0, 64'h0, 64'h00A5, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
